ctrl_issue: RTL and testbench
=============================

// Module: ctrl_issue
// PURPOSE
//  Registered, stall-aware successor to the combinational 9-bit decoder. Sits between the
//  instruction fetch (PC/instr ROM) and the RegFile/ALU/data_mem/Jump_table datapath.
//  Accepts one instruction per valid/ready handshake and issues registered control one cycle
//  later. Owns the Eql/Lss/Grt flag register. Stalls branches on an outstanding compare and
//  stalls fetch during multi-cycle load/store.
// PARAMETERS
//  IW       9  instruction width; encoding below is fixed at 9 bits, IW>9 ignores MSBs above 8
//  MEM_LAT  2  data_mem cycles per LOAD/STORE, range 1..15
//  JT_W     4  Jump_table index width, >=4
// PORTS
//  Clk          in   1      clock, all state on posedge
//  Reset        in   1      synchronous, active-high
//  in_valid     in   1      mach_code valid from fetch
//  in_ready     out  1      ctrl accepts mach_code this cycle
//  mach_code    in   IW     instruction
//  flag_we      in   1      ALU compare result valid this cycle
//  Eql,Lss,Grt  in   1 each ALU compare result, sampled on flag_we
//  out_valid    out  1      issued control valid (1-cycle pulse per instruction)
//  Alu_en       out  1      ALU enable
//  Aluop        out  3      ALU op
//  Ra,Rb        out  3 each register addresses
//  Imm          out  8      zero-extended immediate (PUT, CMPN)
//  Mem_addr     out  3      data_mem slot (LOAD/STORE)
//  WenR,Ldr,Str out  1 each register write / load / store
//  Jen          out  1      take jump
//  Jump_idx     out  JT_W   Jump_table index
//  loop_branch  out  1      unconditional loop jump
//  shift_dir    out  1      1=LSL-field bit set
//  cmp_imm      out  1      CMPN form
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; flags=000; state RUN; flag_pending=0; counters 0.
//  Unused fields are driven 0 (never Z). All outputs are registered, and latency from accept
//  to out_valid is 1 cycle. Accept = in_valid & in_ready.
//  Decode of [8:0]:
//   11_000 BEQ Jen=E | 001 BNE !E | 010 BGT G | 011 BLE L|E | 100 BLT L; Jump_idx=[3:0].
//   11_101,[3]=0 loop jump: Jen=1, loop_branch=1, Jump_idx=[2:0].
//   11_101,[3]=1 FLIP: Alu_en, Aluop=110, Ra=[2:0], WenR.
//   11_110 LOAD: Ra={00,[3]}, Mem_addr=[2:0], WenR, Ldr. 11_111 STORE: same fields, Str.
//   000 MOV, 010 ADD, 011 SUB: Aluop=[8:6], Ra=[5:3], Rb=[2:0], WenR.
//   001 PUT: Aluop=001, Ra=[5:3], Imm=[2:0], WenR.
//   100 SHIFT: Aluop=100, Ra=[4:2], Rb={0,[1:0]}, shift_dir=[5], WenR.
//   101 CMP: Aluop=101, WenR=0, cmp_imm=[5].
//    [5]=0: Ra={0,[4:3]}, Rb=[2:0]. [5]=1: Ra=[4:2], Imm=[1:0].
//   Issuing CMP sets flag_pending.
//  Flags: on flag_we the flag register <= {Eql,Lss,Grt} and flag_pending is cleared.
//  FSM RUN / FLAG_WAIT / MEM_WAIT:
//   RUN: in_ready=1. If a conditional branch is presented while flag_pending & !flag_we,
//    do not accept; go to FLAG_WAIT. On LOAD/STORE accept with MEM_LAT>1, load
//    cnt=MEM_LAT-1 and go to MEM_WAIT.
//   FLAG_WAIT: in_ready=flag_we. Same-cycle flag_we bypasses new flags into Jen.
//    Return to RUN on accept.
//   MEM_WAIT: in_ready=0; cnt decrements each cycle; at cnt==1 go to RUN. Ldr/Str/WenR are
//    asserted only in the issue cycle.
//  Simultaneous CMP issue and flag_we: the older flag_we updates flags, and pending stays set
//   for the new CMP.
//  Unconditional/loop jumps and non-branch instructions never wait on flags.
//  Reset mid-MEM_WAIT/FLAG_WAIT: abandon the instruction, go to RUN, and produce no out_valid.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds out ports issue_cnt[15:0] and stall_cnt[15:0].
//   issue_cnt increments per out_valid; stall_cnt increments per cycle with
//   in_valid & !in_ready. Both saturate at 16'hFFFF and clear on Reset.
//  Undefined: ports and logic are absent.
// TESTING
//  Reset with Reset=1 for 2 cycles -> all outputs 0, in_ready=1; release, then ADD 010_001_010
//   -> next cycle out_valid=1, Aluop=010, Ra=1, Rb=2, WenR=1.
//  CMPN 101_1_011_10 then BEQ 11_000_0101, flag_we 3 cycles later with Eql=1 -> in_ready=0 for
//   2 cycles, BEQ accepted on the flag_we cycle, Jen=1, Jump_idx=5.
//  MEM_LAT=3, LOAD 11_110_1_011 -> Ldr=1, Ra=1, Mem_addr=3 for one cycle; in_ready=0 for
//   2 cycles after accept.
//  Loop jump 11_101_0_110 with flag_pending=1 -> no stall, Jen=1, loop_branch=1, Jump_idx=6.
//  Reset asserted in MEM_WAIT -> next cycle state RUN, in_ready=1, out_valid=0.
//  CTRL_PERF_CNT_EN: 5 instructions with 2 stall cycles -> issue_cnt=5, stall_cnt=2.

Source files
------------

// File: rtl/ctrl_issue.sv
// ctrl_issue: registered, stall-aware instruction decoder/issuer.
// Accepts one 9-bit instruction per valid/ready handshake and presents the decoded
// control one cycle later as a single-cycle out_valid pulse. Holds the Eql/Lss/Grt
// flag register, holds back conditional branches while a compare result is still
// outstanding, and blocks fetch while a load/store occupies data_mem.
// Optional: define CTRL_PERF_CNT_EN to add the saturating issue_cnt/stall_cnt ports.
module ctrl_issue #(
    parameter int IW      = 9,
    parameter int MEM_LAT = 2,
    parameter int JT_W    = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   mach_code,
    input  logic            flag_we,
    input  logic            Eql,
    input  logic            Lss,
    input  logic            Grt,
    output logic            out_valid,
    output logic            Alu_en,
    output logic [2:0]      Aluop,
    output logic [2:0]      Ra,
    output logic [2:0]      Rb,
    output logic [7:0]      Imm,
    output logic [2:0]      Mem_addr,
    output logic            WenR,
    output logic            Ldr,
    output logic            Str,
    output logic            Jen,
    output logic [JT_W-1:0] Jump_idx,
    output logic            loop_branch,
    output logic            shift_dir,
    output logic            cmp_imm
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]     issue_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    typedef enum logic [1:0] {RUN, FLAG_WAIT, MEM_WAIT} state_t;

    typedef struct packed {
        logic            alu_en;
        logic [2:0]      aluop;
        logic [2:0]      ra;
        logic [2:0]      rb;
        logic [7:0]      imm;
        logic [2:0]      mem_addr;
        logic            wenr;
        logic            ldr;
        logic            str;
        logic            jen;
        logic [JT_W-1:0] jump_idx;
        logic            loop_branch;
        logic            shift_dir;
        logic            cmp_imm;
    } ctl_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] flags;          // {E, L, G}
    logic [2:0] flags_eff;
    logic       flag_pending;
    logic [8:0] code;
    logic       is_cond, is_mem, is_cmp, take, accept;
    ctl_t       dec, q;

    // Only the low 9 bits carry the encoding; wider IW is tolerated.
    assign code    = mach_code[8:0];
    assign is_cond = (code[8:7] == 2'b11) && (code[6:4] <= 3'b100);
    assign is_mem  = (code[8:7] == 2'b11) && (code[6:5] == 2'b11);
    assign is_cmp  = (code[8:6] == 3'b101);
    assign accept  = in_valid && in_ready;

    // Branch condition; a flag write in the same cycle is bypassed so a held branch
    // resolves against the fresh compare result.
    always_comb begin
        flags_eff = flag_we ? {Eql, Lss, Grt} : flags;
        take      = 1'b0;
        case (code[6:4])
            3'b000:  take = flags_eff[2];
            3'b001:  take = !flags_eff[2];
            3'b010:  take = flags_eff[0];
            3'b011:  take = flags_eff[1] || flags_eff[2];
            3'b100:  take = flags_eff[1];
            default: take = 1'b0;
        endcase
    end

    // Instruction decode; every field not used by an instruction stays 0.
    always_comb begin
        dec = '0;
        if (code[8:7] == 2'b11) begin
            case (code[6:4])
                3'b101: begin
                    if (!code[3]) begin
                        dec.jen           = 1'b1;
                        dec.loop_branch   = 1'b1;
                        dec.jump_idx[2:0] = code[2:0];
                    end else begin
                        dec.alu_en = 1'b1;
                        dec.aluop  = 3'b110;
                        dec.ra     = code[2:0];
                        dec.wenr   = 1'b1;
                    end
                end
                3'b110, 3'b111: begin
                    dec.ra       = {2'b00, code[3]};
                    dec.mem_addr = code[2:0];
                    dec.wenr     = !code[4];
                    dec.ldr      = !code[4];
                    dec.str      = code[4];
                end
                default: begin
                    dec.jen           = take;
                    dec.jump_idx[3:0] = code[3:0];
                end
            endcase
        end else begin
            dec.alu_en = 1'b1;
            dec.aluop  = code[8:6];
            case (code[8:6])
                3'b001: begin
                    dec.ra   = code[5:3];
                    dec.imm  = {5'b0, code[2:0]};
                    dec.wenr = 1'b1;
                end
                3'b100: begin
                    dec.ra        = code[4:2];
                    dec.rb        = {1'b0, code[1:0]};
                    dec.shift_dir = code[5];
                    dec.wenr      = 1'b1;
                end
                3'b101: begin
                    dec.cmp_imm = code[5];
                    if (code[5]) begin
                        dec.ra  = code[4:2];
                        dec.imm = {6'b0, code[1:0]};
                    end else begin
                        dec.ra = {1'b0, code[4:3]};
                        dec.rb = code[2:0];
                    end
                end
                default: begin
                    dec.ra   = code[5:3];
                    dec.rb   = code[2:0];
                    dec.wenr = 1'b1;
                end
            endcase
        end
    end

    // Handshake and next-state: hold conditional branches on an outstanding compare,
    // block fetch for the remainder of a multi-cycle memory access.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        in_ready = 1'b0;
        case (state)
            RUN: begin
                in_ready = !(in_valid && is_cond && flag_pending && !flag_we);
                if (in_valid && !in_ready) state_nx = FLAG_WAIT;
            end
            FLAG_WAIT: begin
                in_ready = flag_we;
                // Pending clears on flag_we, so nothing is left to wait for.
                if (flag_we) state_nx = RUN;
            end
            MEM_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        if (accept && is_mem && (MEM_LAT > 1)) begin
            state_nx = MEM_WAIT;
            cnt_nx   = 4'(MEM_LAT - 1);
        end
    end

    // State, flag register and pending-compare tracking; a new CMP wins over a
    // simultaneous flag write, which belongs to the older compare.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= RUN;
            cnt          <= '0;
            flags        <= '0;
            flag_pending <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (flag_we) flags <= {Eql, Lss, Grt};
            if (accept && is_cmp) flag_pending <= 1'b1;
            else if (flag_we)     flag_pending <= 1'b0;
        end
    end

    // Issue register: control is live only in the cycle after accept.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            out_valid <= accept;
            q         <= accept ? dec : '0;
        end
    end

    assign Alu_en      = q.alu_en;
    assign Aluop       = q.aluop;
    assign Ra          = q.ra;
    assign Rb          = q.rb;
    assign Imm         = q.imm;
    assign Mem_addr    = q.mem_addr;
    assign WenR        = q.wenr;
    assign Ldr         = q.ldr;
    assign Str         = q.str;
    assign Jen         = q.jen;
    assign Jump_idx    = q.jump_idx;
    assign loop_branch = q.loop_branch;
    assign shift_dir   = q.shift_dir;
    assign cmp_imm     = q.cmp_imm;

`ifdef CTRL_PERF_CNT_EN
    // Saturating counters of issued instructions and fetch-stall cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && (issue_cnt != 16'hFFFF)) issue_cnt <= issue_cnt + 16'd1;
            if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_issue.sv
// tb_ctrl_issue: directed vectors with a scoreboard. The driver pushes the
// hand-computed control word when an instruction is accepted; the monitor pops and
// compares on every out_valid. Handshake/stall timing is checked inline.
module tb_ctrl_issue;

    typedef struct packed {
        logic       alu_en;
        logic [2:0] aluop;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic [2:0] mem_addr;
        logic       wenr;
        logic       ldr;
        logic       str;
        logic       jen;
        logic [3:0] jump_idx;
        logic       loop_branch;
        logic       shift_dir;
        logic       cmp_imm;
    } ctl_t;

    logic       Clk, Reset, in_valid, in_ready, flag_we, Eql, Lss, Grt;
    logic [8:0] mach_code;
    logic       out_valid, Alu_en, WenR, Ldr, Str, Jen, loop_branch, shift_dir, cmp_imm;
    logic [2:0] Aluop, Ra, Rb, Mem_addr;
    logic [7:0] Imm;
    logic [3:0] Jump_idx;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] issue_cnt, stall_cnt;
`endif

    ctl_t dut_ctl, mon_x;
    ctl_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    ctrl_issue #(.IW(9), .MEM_LAT(3), .JT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .mach_code(mach_code), .flag_we(flag_we), .Eql(Eql), .Lss(Lss), .Grt(Grt),
        .out_valid(out_valid), .Alu_en(Alu_en), .Aluop(Aluop), .Ra(Ra), .Rb(Rb),
        .Imm(Imm), .Mem_addr(Mem_addr), .WenR(WenR), .Ldr(Ldr), .Str(Str), .Jen(Jen),
        .Jump_idx(Jump_idx), .loop_branch(loop_branch), .shift_dir(shift_dir),
        .cmp_imm(cmp_imm)
`ifdef CTRL_PERF_CNT_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    assign dut_ctl = {Alu_en, Aluop, Ra, Rb, Imm, Mem_addr, WenR, Ldr, Str, Jen,
                      Jump_idx, loop_branch, shift_dir, cmp_imm};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic ctl_t alu(input logic [2:0] op, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic [7:0] imm,
                                 input logic wen, input logic shd, input logic cmpi);
        ctl_t x = '0;
        x.alu_en = 1'b1; x.aluop = op; x.ra = ra; x.rb = rb; x.imm = imm;
        x.wenr = wen; x.shift_dir = shd; x.cmp_imm = cmpi;
        return x;
    endfunction

    function automatic ctl_t br(input logic jen, input logic [3:0] idx, input logic lp);
        ctl_t x = '0;
        x.jen = jen; x.jump_idx = idx; x.loop_branch = lp;
        return x;
    endfunction

    function automatic ctl_t mem(input logic [2:0] ra, input logic [2:0] addr,
                                 input logic ld, input logic st);
        ctl_t x = '0;
        x.ra = ra; x.mem_addr = addr; x.wenr = ld; x.ldr = ld; x.str = st;
        return x;
    endfunction

    // Present one instruction until accepted; returns the number of stall cycles.
    // Ends at the negedge following the accept edge with in_valid dropped.
    task automatic send(input logic [8:0] c, input ctl_t x, output int stalls);
        in_valid  = 1'b1;
        mach_code = c;
        stalls    = 0;
        #1;
        while (!in_ready && stalls < 20) begin
            @(negedge Clk); #1;
            stalls++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(stalls), 32'd0);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(x);
            @(negedge Clk);
            in_valid = 1'b0;
            chk("issue_latency", 32'(out_valid), 32'd1);
        end
    endtask

    // Branch held for a number of cycles, then released by flag_we carrying elg={E,L,G}.
    task automatic held_branch(input logic [8:0] c, input ctl_t x, input int stalls,
                               input logic [2:0] elg);
        in_valid  = 1'b1;
        mach_code = c;
        for (int i = 0; i < stalls; i++) begin
            #1; chk("branch_held", 32'(in_ready), 32'd0);
            @(negedge Clk);
        end
        {Eql, Lss, Grt} = elg;
        flag_we = 1'b1;
        #1; chk("branch_release", 32'(in_ready), 32'd1);
        exp_q.push_back(x);
        @(negedge Clk);
        in_valid = 1'b0;
        flag_we  = 1'b0;
        chk("branch_latency", 32'(out_valid), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge Clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=%h required=none", dut_ctl);
            end else begin
                mon_x = exp_q.pop_front();
                chk("issue_ctl", dut_ctl, mon_x);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; mach_code = '0;
        flag_we = 1'b0; Eql = 1'b0; Lss = 1'b0; Grt = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ctl", dut_ctl, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        Reset = 1'b0;

        // ALU-class decode
        send(9'b010001010, alu(3'b010, 3'd1, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0), n);
        send(9'b000011101, alu(3'b000, 3'd3, 3'd5, 8'd0, 1'b1, 1'b0, 1'b0), n);
        send(9'b011111000, alu(3'b011, 3'd7, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0), n);
        send(9'b001110101, alu(3'b001, 3'd6, 3'd0, 8'd5, 1'b1, 1'b0, 1'b0), n);
        send(9'b100101101, alu(3'b100, 3'd3, 3'd1, 8'd0, 1'b1, 1'b1, 1'b0), n);
        send(9'b111011100, alu(3'b110, 3'd4, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0), n);

        // CMPN then BEQ held 2 cycles, released by flag_we with Eql=1
        send(9'b101101110, alu(3'b101, 3'd3, 3'd0, 8'd2, 1'b0, 1'b0, 1'b1), n);
        held_branch(9'b110000101, br(1'b1, 4'd5, 1'b0), 2, 3'b100);

        // Branches against stored flags E=1,L=0,G=0
        send(9'b110010011, br(1'b0, 4'd3, 1'b0), n);
        send(9'b110111010, br(1'b1, 4'd10, 1'b0), n);
        send(9'b110100001, br(1'b0, 4'd1, 1'b0), n);
        send(9'b111001111, br(1'b0, 4'd15, 1'b0), n);
        chk("cond_no_pending_stall", 32'(n), 32'd0);

        // Register CMP leaves a compare outstanding; loop jump and PUT do not wait
        send(9'b101010110, alu(3'b101, 3'd2, 3'd6, 8'd0, 1'b0, 1'b0, 1'b0), n);
        send(9'b111010110, br(1'b1, 4'd6, 1'b1), n);
        chk("loop_no_stall", 32'(n), 32'd0);
        send(9'b001110101, alu(3'b001, 3'd6, 3'd0, 8'd5, 1'b1, 1'b0, 1'b0), n);
        chk("alu_no_stall", 32'(n), 32'd0);
        {Eql, Lss, Grt} = 3'b010;
        flag_we = 1'b1;
        @(negedge Clk);
        flag_we = 1'b0;
        send(9'b111000111, br(1'b1, 4'd7, 1'b0), n);
        chk("blt_after_flags", 32'(n), 32'd0);
        send(9'b110000000, br(1'b0, 4'd0, 1'b0), n);

        // CMP issued together with an older flag_we: pending must survive
        {Eql, Lss, Grt} = 3'b001;
        flag_we = 1'b1;
        send(9'b101101110, alu(3'b101, 3'd3, 3'd0, 8'd2, 1'b0, 1'b0, 1'b1), n);
        flag_we = 1'b0;
        held_branch(9'b110100010, br(1'b1, 4'd2, 1'b0), 1, 3'b001);

        // LOAD with MEM_LAT=3: two blocked cycles, control only in issue cycle
        send(9'b111101011, mem(3'd1, 3'd3, 1'b1, 1'b0), n);
        #1; chk("mem_wait1", 32'(in_ready), 32'd0);
        @(negedge Clk); #1;
        chk("mem_wait2", 32'(in_ready), 32'd0);
        chk("ldr_one_cycle", 32'(Ldr), 32'd0);
        @(negedge Clk); #1;
        chk("mem_done", 32'(in_ready), 32'd1);
        @(negedge Clk);
        send(9'b111110101, mem(3'd0, 3'd5, 1'b0, 1'b1), n);
        send(9'b010001010, alu(3'b010, 3'd1, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0), n);
        chk("store_stall", 32'(n), 32'd2);

        // Reset during MEM_WAIT with an instruction waiting
        send(9'b111101011, mem(3'd1, 3'd3, 1'b1, 1'b0), n);
        Reset = 1'b1; in_valid = 1'b1; mach_code = 9'b010001010;
        @(negedge Clk);
        chk("rst_mem_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_valid", 32'(out_valid), 32'd0);
        Reset = 1'b0; in_valid = 1'b0;
        @(negedge Clk);
        chk("rst_mem_quiet", 32'(out_valid), 32'd0);

        // Reset during FLAG_WAIT abandons the held branch
        send(9'b101101110, alu(3'b101, 3'd3, 3'd0, 8'd2, 1'b0, 1'b0, 1'b1), n);
        in_valid = 1'b1; mach_code = 9'b110000101;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_flag_valid", 32'(out_valid), 32'd0);
        Reset = 1'b0; in_valid = 1'b0;
        @(negedge Clk);
        chk("rst_flag_quiet", 32'(out_valid), 32'd0);
        chk("rst_flag_ready", 32'(in_ready), 32'd1);

        // Five issues with two stall cycles since the last reset
        send(9'b101101110, alu(3'b101, 3'd3, 3'd0, 8'd2, 1'b0, 1'b0, 1'b1), n);
        held_branch(9'b110000101, br(1'b1, 4'd5, 1'b0), 2, 3'b100);
        send(9'b010001010, alu(3'b010, 3'd1, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0), n);
        send(9'b000011101, alu(3'b000, 3'd3, 3'd5, 8'd0, 1'b1, 1'b0, 1'b0), n);
        send(9'b011111000, alu(3'b011, 3'd7, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0), n);
        @(negedge Clk);
`ifdef CTRL_PERF_CNT_EN
        chk("issue_cnt", 32'(issue_cnt), 32'd5);
        chk("stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
